cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle control unit for the 8-bit datapath.
- Fetches an instruction word from instruction ROM, decodes it, and sequences the operand muxes (A/B/0/mem on port A; A/B/K/mem on port B), ALU op, register loads and data-memory read/write.
- Data memory is accessed over a req/ack handshake.
- Owns the PC and the zero flag; supports unconditional jumps, jump-if-zero and halt.

Parameters:
- INSTR_W, 20, instruction word width (field map below is fixed for 20).
- PC_W, 8, program counter / instruction address width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- im_addr  out  PC_W  instruction ROM address (ROM is synchronous, 1-cycle read)
- im_data  in  INSTR_W  instruction word
- alu_zero  in  1  ALU result == 0 (combinational from datapath)
- mem_req  out  1  data-memory request
- mem_we  out  1  1=write, 0=read; valid while mem_req=1
- mem_ack  in  1  memory completes the request this cycle
- mem_addr_sel  out  1  0: mem address = K, 1: mem address = reg B
- mdr_load  out  1  capture memory read data into datapath MDR
- sel_a  out  2  port-A mux: 00 A, 01 B, 10 zero, 11 MDR
- sel_b  out  2  port-B mux: 00 A, 01 B, 10 K, 11 MDR
- alu_op  out  3  ALU operation, passed through from instruction
- k_out  out  8  literal K
- load_a  out  1  write ALU result to A
- load_b  out  1  write ALU result to B
- halted  out  1  sequencer is in HALT

Behaviour:
Instruction fields:
- [19:18] kind: 00 ALU, 01 JMP, 10 JEQ, 11 HALT
- [17:15] alu_op; [14:13] sel_a; [12:11] sel_b
- [10:9] dst: 00 none, 01 A, 10 B, 11 mem
- [8] mem_addr_sel; [7:0] K

Reset (async, immediate):
- state=FETCH, pc=0, ir=0, z_flag=0.
- All outputs 0; im_addr=0.
- Reset mid-transaction drops mem_req the same instant. No pending memory operation is remembered.

States:
- FETCH: im_addr=pc. Next state DECODE.
- DECODE:
  - ir <= im_data.
  - kind=HALT -> HALT.
  - kind=JMP -> pc <= K, next FETCH.
  - kind=JEQ -> pc <= z_flag ? K : pc+1, next FETCH.
  - ALU with sel_a==11 or sel_b==11 -> MEM_RD.
  - Otherwise -> EXEC.
- MEM_RD:
  - mem_req=1, mem_we=0, mem_addr_sel=ir[8].
  - Hold until mem_ack. On the ack cycle mdr_load=1, then go to EXEC.
- EXEC:
  - sel_a, sel_b, alu_op, k_out driven from ir.
  - dst=01 -> load_a=1; dst=10 -> load_b=1 (single-cycle pulse).
  - z_flag <= alu_zero when dst != 00.
  - dst=11 -> MEM_WR; else pc <= pc+1, next FETCH.
- MEM_WR:
  - mem_req=1, mem_we=1, mem_addr_sel=ir[8]; sel/alu_op held so write data is stable.
  - On mem_ack: pc <= pc+1, next FETCH.
  - z_flag updates from alu_zero on the ack cycle.
- HALT: halted=1, all other strobes 0. Leave only via reset.

Timing and boundary rules:
- sel_a/sel_b/alu_op/k_out outside EXEC/MEM_WR: 00/00/000/0x00.
- load_a/load_b/mdr_load are never asserted in the same cycle as each other except load_* with nothing else.
- Latency: ALU w/o memory = 3 cycles; +1 cycle per memory phase minimum (ack in first request cycle); JMP/JEQ = 2 cycles.
- mem_req stays high and its attributes stable until mem_ack; mem_ack while mem_req=0 is ignored.
- pc wraps 255 -> 0 on increment.
- A read and a write both in one instruction (sel==11 and dst==11) perform MEM_RD then MEM_WR to the same address.

Decomposition:
- Package cpu_pkg holds:
  - kind encodings and state enum (FETCH, DECODE, MEM_RD, EXEC, MEM_WR, HALT);
  - mux select constants (SEL_A, SEL_B, SEL_ZERO/SEL_K, SEL_MEM);
  - dst encodings;
  - field bit-position constants.
- One natural sub-module: cpu_decode (combinational ir -> field signals and needs_mem_rd/needs_mem_wr).
- FSM, PC and z_flag stay in cpu_sequencer.

Test Plan:
1. Reset asserted mid-MEM_RD with mem_req=1 -> mem_req, pc, halted all 0 asynchronously; after release, im_addr=0 and FETCH.
2. ROM[0]={ALU, op=ADD, sel_a=00, sel_b=10, dst=01, K=0x05} -> load_a pulses in cycle 3 with sel_b=10, k_out=0x05; im_addr=1 on the next FETCH.
3. ROM[0] reads mem (sel_b=11, K=0x20, mem_addr_sel=0), mem_ack delayed 3 cycles -> mem_req high exactly 3 cycles, mdr_load on the ack cycle only, load_b next cycle.
4. ALU with dst=11, mem_addr_sel=1 -> MEM_WR with mem_we=1, mem_addr_sel=1, sel lines held until ack; no load_a/load_b.
5. ALU result zero (alu_zero=1, dst=01), then JEQ K=0x40 -> im_addr=0x40; repeat with alu_zero=0 -> im_addr=pc+1; PC at 0xFF increments to 0x00.
6. HALT at ROM[3] -> halted=1 from cycle after DECODE, im_addr frozen, no strobes for 20 cycles, cleared only by reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle sequencer of the 8-bit datapath.
// Holds the instruction kind and state encodings, the operand mux select
// codes, the destination codes and the bit positions of every field in the
// 20-bit instruction word.
package cpu_pkg;

    // Field map of the 20-bit instruction word:
    // [19:18] kind, [17:15] alu_op, [14:13] sel_a, [12:11] sel_b,
    // [10:9] dst, [8] mem_addr_sel, [7:0] K
    localparam int FIELD_KIND_LSB  = 18;
    localparam int FIELD_OP_LSB    = 15;
    localparam int FIELD_SEL_A_LSB = 13;
    localparam int FIELD_SEL_B_LSB = 11;
    localparam int FIELD_DST_LSB   = 9;
    localparam int FIELD_MAS_BIT   = 8;
    localparam int FIELD_K_LSB     = 0;

    typedef enum logic [1:0] {
        KIND_ALU  = 2'b00,
        KIND_JMP  = 2'b01,
        KIND_JEQ  = 2'b10,
        KIND_HALT = 2'b11
    } kind_t;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MEM_RD = 3'd2,
        EXEC   = 3'd3,
        MEM_WR = 3'd4,
        HALT   = 3'd5
    } state_t;

    // Operand mux selects. Code 10 means "zero" on port A and "K" on port B.
    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_ZERO = 2'b10;
    localparam logic [1:0] SEL_K    = 2'b10;
    localparam logic [1:0] SEL_MEM  = 2'b11;

    // Destination of the ALU result.
    localparam logic [1:0] DST_NONE = 2'b00;
    localparam logic [1:0] DST_A    = 2'b01;
    localparam logic [1:0] DST_B    = 2'b10;
    localparam logic [1:0] DST_MEM  = 2'b11;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Data-memory request bus between the sequencer and the data memory.
//   mem_req      : request pending (master)
//   mem_we       : 1 = write, 0 = read, meaningful while mem_req = 1 (master)
//   mem_addr_sel : 0 = address is K, 1 = address is register B (master)
//   mem_ack      : memory completes the request this cycle (slave)
// Handshake: once mem_req rises, it and its attributes (mem_we, mem_addr_sel)
// stay stable until the cycle in which mem_ack = 1; that cycle completes the
// transfer. mem_ack while mem_req = 0 carries no meaning and is ignored.
interface cpu_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ack;

    modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ack);
    modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ack);
endinterface

// File: rtl/cpu_decode.sv
// Combinational instruction decoder.
//   instr        : instruction word
//   kind         : ALU / JMP / JEQ / HALT
//   alu_op, sel_a, sel_b, dst, mem_addr_sel, k : raw fields
//   needs_mem_rd : ALU instruction with a memory operand on either port
//   needs_mem_wr : ALU instruction whose result goes to memory
module cpu_decode
    import cpu_pkg::*;
#(
    parameter int INSTR_W = 20
) (
    input  logic [INSTR_W-1:0] instr,
    output kind_t              kind,
    output logic [2:0]         alu_op,
    output logic [1:0]         sel_a,
    output logic [1:0]         sel_b,
    output logic [1:0]         dst,
    output logic               mem_addr_sel,
    output logic [7:0]         k,
    output logic               needs_mem_rd,
    output logic               needs_mem_wr
);

    assign kind         = kind_t'(instr[FIELD_KIND_LSB +: 2]);
    assign alu_op       = instr[FIELD_OP_LSB +: 3];
    assign sel_a        = instr[FIELD_SEL_A_LSB +: 2];
    assign sel_b        = instr[FIELD_SEL_B_LSB +: 2];
    assign dst          = instr[FIELD_DST_LSB +: 2];
    assign mem_addr_sel = instr[FIELD_MAS_BIT];
    assign k            = instr[FIELD_K_LSB +: 8];

    assign needs_mem_rd = (kind == KIND_ALU) && ((sel_a == SEL_MEM) || (sel_b == SEL_MEM));
    assign needs_mem_wr = (kind == KIND_ALU) && (dst == DST_MEM);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit for the 8-bit datapath. Fetches from a
// synchronous instruction ROM, decodes, and sequences operand muxes, ALU op,
// register loads and data-memory reads/writes. Owns the PC and zero flag.
//   clk, reset   : clock (rising edge), asynchronous active-high reset
//   im_addr      : instruction ROM address (always the PC)
//   im_data      : instruction word, valid in the cycle after im_addr
//   alu_zero     : datapath ALU result is zero
//   mem          : data-memory request bus (master side)
//   mdr_load     : capture memory read data into the MDR
//   sel_a, sel_b : operand mux selects
//   alu_op, k_out: ALU operation and literal, driven only in EXEC/MEM_WR
//   load_a/load_b: write ALU result into A / B
//   halted       : sequencer sits in HALT
//   state_dbg    : current FSM state
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int INSTR_W = 20,
    parameter int PC_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    im_addr,
    input  logic [INSTR_W-1:0] im_data,
    input  logic               alu_zero,
    cpu_sequencer_if.master    mem,
    output logic               mdr_load,
    output logic [1:0]         sel_a,
    output logic [1:0]         sel_b,
    output logic [2:0]         alu_op,
    output logic [7:0]         k_out,
    output logic               load_a,
    output logic               load_b,
    output logic               halted,
    output state_t             state_dbg
);

    state_t             state, state_n;
    logic [PC_W-1:0]    pc, pc_n;
    logic [INSTR_W-1:0] ir, ir_n;
    logic               z_flag, z_n;

    kind_t      d_kind;
    logic [2:0] d_op;
    logic [1:0] d_sel_a, d_sel_b, d_dst;
    logic       d_mas, d_rd, d_wr;
    logic [7:0] d_k;
    logic       req_c, we_c, mas_c;

    // In DECODE the ROM word has not been latched into ir yet, so decode it
    // directly; in every later state the latched ir is the source.
    cpu_decode #(.INSTR_W(INSTR_W)) u_decode (
        .instr        ((state == DECODE) ? im_data : ir),
        .kind         (d_kind),
        .alu_op       (d_op),
        .sel_a        (d_sel_a),
        .sel_b        (d_sel_b),
        .dst          (d_dst),
        .mem_addr_sel (d_mas),
        .k            (d_k),
        .needs_mem_rd (d_rd),
        .needs_mem_wr (d_wr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= FETCH;
            pc     <= '0;
            ir     <= '0;
            z_flag <= 1'b0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            ir     <= ir_n;
            z_flag <= z_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        ir_n     = ir;
        z_n      = z_flag;
        req_c    = 1'b0;
        we_c     = 1'b0;
        mas_c    = 1'b0;
        mdr_load = 1'b0;
        sel_a    = 2'b00;
        sel_b    = 2'b00;
        alu_op   = 3'b000;
        k_out    = 8'h00;
        load_a   = 1'b0;
        load_b   = 1'b0;
        halted   = 1'b0;
        case (state)
            FETCH: state_n = DECODE;
            DECODE: begin
                ir_n = im_data;
                case (d_kind)
                    KIND_HALT: state_n = HALT;
                    KIND_JMP: begin
                        pc_n    = PC_W'(d_k);
                        state_n = FETCH;
                    end
                    KIND_JEQ: begin
                        pc_n    = z_flag ? PC_W'(d_k) : pc + PC_W'(1);
                        state_n = FETCH;
                    end
                    default: state_n = d_rd ? MEM_RD : EXEC;
                endcase
            end
            MEM_RD: begin
                req_c = 1'b1;
                mas_c = d_mas;
                if (mem.mem_ack) begin
                    mdr_load = 1'b1;
                    state_n  = EXEC;
                end
            end
            EXEC: begin
                sel_a  = d_sel_a;
                sel_b  = d_sel_b;
                alu_op = d_op;
                k_out  = d_k;
                load_a = (d_dst == DST_A);
                load_b = (d_dst == DST_B);
                if (d_dst != DST_NONE) z_n = alu_zero;
                if (d_wr) begin
                    state_n = MEM_WR;
                end else begin
                    pc_n    = pc + PC_W'(1);
                    state_n = FETCH;
                end
            end
            MEM_WR: begin
                // Operand selects stay driven so the write data is stable.
                req_c  = 1'b1;
                we_c   = 1'b1;
                mas_c  = d_mas;
                sel_a  = d_sel_a;
                sel_b  = d_sel_b;
                alu_op = d_op;
                k_out  = d_k;
                if (mem.mem_ack) begin
                    z_n     = alu_zero;
                    pc_n    = pc + PC_W'(1);
                    state_n = FETCH;
                end
            end
            HALT: halted = 1'b1;
            default: state_n = FETCH;
        endcase
    end

    assign mem.mem_req      = req_c;
    assign mem.mem_we       = we_c;
    assign mem.mem_addr_sel = mas_c;
    assign im_addr          = pc;
    assign state_dbg        = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed programs in a model ROM, a data-memory
// responder with programmable ack delay, and an event scoreboard keyed by
// cycle number since reset release.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    typedef struct packed {
        logic [7:0] cyc;
        logic [7:0] im;
        logic [3:0] memf;   // {mem_req, mem_we, mem_addr_sel, mdr_load}
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] op;
        logic [7:0] k;
        logic [2:0] flags;  // {load_a, load_b, halted}
    } obs_t;
    localparam int OBS_W = $bits(obs_t);

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [7:0]  im_addr;
    logic [19:0] im_data;
    logic        alu_zero;
    logic        mdr_load, load_a, load_b, halted;
    logic [1:0]  sel_a, sel_b;
    logic [2:0]  alu_op;
    logic [7:0]  k_out;
    state_t      state_dbg;

    cpu_sequencer_if mem_if();

    cpu_sequencer #(.INSTR_W(20), .PC_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .im_addr   (im_addr),
        .im_data   (im_data),
        .alu_zero  (alu_zero),
        .mem       (mem_if.master),
        .mdr_load  (mdr_load),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .alu_op    (alu_op),
        .k_out     (k_out),
        .load_a    (load_a),
        .load_b    (load_b),
        .halted    (halted),
        .state_dbg (state_dbg)
    );

    // ROM, per-address ALU zero result, cycle counter
    logic [19:0] rom  [256];
    logic        zrom [256];
    int          cyc;

    always @(posedge clk) im_data <= rom[im_addr];
    assign alu_zero = zrom[im_addr];

    always @(posedge clk or posedge reset)
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;

    // data-memory responder; ack on the ack_delay-th request cycle,
    // spurious ack pulses on odd cycles while no request is pending
    int ack_delay;
    int req_cnt;
    logic noise_en;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            req_cnt        = 0;
            mem_if.mem_ack = 1'b0;
        end else if (mem_if.mem_req) begin
            req_cnt        = req_cnt + 1;
            mem_if.mem_ack = (req_cnt == ack_delay);
        end else begin
            req_cnt        = 0;
            mem_if.mem_ack = noise_en & cyc[0];
        end
    end

    // scoreboard
    logic [OBS_W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [OBS_W-1:0] mk(input int c, input logic [7:0] im,
                                            input logic [3:0] memf, input logic [1:0] sa,
                                            input logic [1:0] sb, input logic [2:0] op,
                                            input logic [7:0] k, input logic [2:0] flags);
        obs_t o;
        o.cyc = c[7:0]; o.im = im; o.memf = memf; o.sa = sa; o.sb = sb;
        o.op = op; o.k = k; o.flags = flags;
        return o;
    endfunction

    task automatic expect_ev(input int c, input logic [7:0] im, input logic [3:0] memf,
                             input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] op,
                             input logic [7:0] k, input logic [2:0] flags);
        exp_q.push_back(mk(c, im, memf, sa, sb, op, k, flags));
    endtask

    // monitor: any strobe or the rising edge of halted is an event
    logic halted_q;
    always @(negedge clk) begin
        if (reset) begin
            halted_q = 1'b0;
        end else begin
            if (mem_if.mem_req | mdr_load | load_a | load_b | (halted & ~halted_q)) begin
                logic [OBS_W-1:0] act;
                act = mk(cyc, im_addr, {mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr_sel, mdr_load},
                         sel_a, sel_b, alu_op, k_out, {load_a, load_b, halted});
                if (exp_q.size() == 0) chk("unexpected_event", 64'(act), 64'(0));
                else                   chk("event", 64'(act), 64'(exp_q.pop_front()));
            end
            halted_q = halted;
        end
    end

    // driver helpers
    function automatic logic [19:0] enc(input logic [1:0] kind, input logic [2:0] op,
                                        input logic [1:0] sa, input logic [1:0] sb,
                                        input logic [1:0] dst, input logic mas,
                                        input logic [7:0] k);
        return {kind, op, sa, sb, dst, mas, k};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) begin
            rom[i]  = enc(2'b11, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00);
            zrom[i] = 1'b0;
        end
    endtask

    task automatic run_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk(name, {im_addr, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr_sel, mdr_load,
                   sel_a, sel_b, alu_op, k_out, load_a, load_b, halted}, 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        noise_en       = 1'b1;
        ack_delay      = 3;
        mem_if.mem_ack = 1'b0;
        clear_rom();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", 64'(state_dbg), 64'(FETCH));
        chk_idle_outputs("reset_outputs");

        // Program A: ALU to A, ALU to mem (write), JMP, read-operand ALU to B, HALT
        rom[8'h00] = enc(2'b00, 3'd1, 2'b00, 2'b10, 2'b01, 1'b0, 8'h05);
        rom[8'h01] = enc(2'b00, 3'd2, 2'b00, 2'b01, 2'b11, 1'b1, 8'h00);
        rom[8'h02] = enc(2'b01, 3'd0, 2'b00, 2'b00, 2'b00, 1'b0, 8'h10);
        rom[8'h10] = enc(2'b00, 3'd3, 2'b01, 2'b11, 2'b10, 1'b0, 8'h20);
        rom[8'h11] = enc(2'b11, 3'd0, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00);
        expect_ev(2,  8'h00, 4'b0000, 2'b00, 2'b10, 3'd1, 8'h05, 3'b100);
        for (int c = 6; c <= 8; c++)
            expect_ev(c, 8'h01, 4'b1110, 2'b00, 2'b01, 3'd2, 8'h00, 3'b000);
        expect_ev(13, 8'h10, 4'b1000, 2'b00, 2'b00, 3'd0, 8'h00, 3'b000);
        expect_ev(14, 8'h10, 4'b1000, 2'b00, 2'b00, 3'd0, 8'h00, 3'b000);
        expect_ev(15, 8'h10, 4'b1001, 2'b00, 2'b00, 3'd0, 8'h00, 3'b000);
        expect_ev(16, 8'h10, 4'b0000, 2'b01, 2'b11, 3'd3, 8'h20, 3'b010);
        expect_ev(19, 8'h11, 4'b0000, 2'b00, 2'b00, 3'd0, 8'h00, 3'b001);
        #1 reset = 1'b0;
        run_until(40);
        #1;
        chk("halt_held", 64'(halted), 64'(1));
        chk("halt_im_addr_frozen", 64'(im_addr), 64'(8'h11));
        chk("halt_state", 64'(state_dbg), 64'(HALT));
        chk("prog_a_events_left", 64'(exp_q.size()), 64'(0));
        #1 reset = 1'b1;
        #1;
        chk("halt_cleared_by_reset", 64'(halted), 64'(0));
        chk("state_after_reset", 64'(state_dbg), 64'(FETCH));

        // Program B: zero flag, JEQ taken / not taken, PC wrap 0xFF -> 0x00
        @(negedge clk);
        clear_rom();
        rom[8'h00] = enc(2'b01, 3'd0, 2'b00, 2'b00, 2'b00, 1'b0, 8'h30);
        rom[8'h30] = enc(2'b00, 3'd0, 2'b10, 2'b10, 2'b01, 1'b0, 8'h00);
        zrom[8'h30] = 1'b1;
        rom[8'h31] = enc(2'b10, 3'd0, 2'b00, 2'b00, 2'b00, 1'b0, 8'h40);
        rom[8'h40] = enc(2'b00, 3'd0, 2'b00, 2'b10, 2'b01, 1'b0, 8'h01);
        rom[8'h41] = enc(2'b10, 3'd0, 2'b00, 2'b00, 2'b00, 1'b0, 8'h10);
        rom[8'h42] = enc(2'b01, 3'd0, 2'b00, 2'b00, 2'b00, 1'b0, 8'hFF);
        rom[8'hFF] = enc(2'b00, 3'd4, 2'b00, 2'b10, 2'b10, 1'b0, 8'h07);
        expect_ev(4,  8'h30, 4'b0000, 2'b10, 2'b10, 3'd0, 8'h00, 3'b100);
        expect_ev(9,  8'h40, 4'b0000, 2'b00, 2'b10, 3'd0, 8'h01, 3'b100);
        expect_ev(16, 8'hFF, 4'b0000, 2'b00, 2'b10, 3'd4, 8'h07, 3'b010);
        expect_ev(21, 8'h30, 4'b0000, 2'b10, 2'b10, 3'd0, 8'h00, 3'b100);
        #1 reset = 1'b0;
        run_until(22);
        chk("prog_b_events_left", 64'(exp_q.size()), 64'(0));
        #2 reset = 1'b1;

        // Program C: reset asserted while a read request is outstanding
        @(negedge clk);
        clear_rom();
        ack_delay = 200;
        rom[8'h00] = enc(2'b01, 3'd0, 2'b00, 2'b00, 2'b00, 1'b0, 8'h50);
        rom[8'h50] = enc(2'b00, 3'd5, 2'b11, 2'b00, 2'b01, 1'b1, 8'h33);
        for (int c = 4; c <= 6; c++)
            expect_ev(c, 8'h50, 4'b1010, 2'b00, 2'b00, 3'd0, 8'h00, 3'b000);
        #1 reset = 1'b0;
        run_until(6);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_mem_req", 64'(mem_if.mem_req), 64'(0));
        chk("async_reset_pc", 64'(im_addr), 64'(0));
        chk("async_reset_halted", 64'(halted), 64'(0));
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("release_state", 64'(state_dbg), 64'(FETCH));
        chk("release_im_addr", 64'(im_addr), 64'(0));
        chk("prog_c_events_left", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
        chk("release_no_stale_request", 64'(mem_if.mem_req), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
